// File: rtl/control_unit.sv
// Main control decoder for the RV32 datapath: maps the 7-bit major opcode to
// registered steering signals for the ALU control, data memory and register file.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] instruction,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_to_reg,
  output logic [1:0] alu_op,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic       illegal
);

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  logic       d_branch;
  logic       d_mem_read;
  logic       d_mem_to_reg;
  logic [1:0] d_alu_op;
  logic       d_mem_write;
  logic       d_alu_src;
  logic       d_reg_write;
  logic       d_illegal;

  // Full 7-bit match; table don't-cares are driven to 0.
  always_comb begin
    d_branch     = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_op     = ALU_ADD;
    d_mem_write  = 1'b0;
    d_alu_src    = 1'b0;
    d_reg_write  = 1'b0;
    d_illegal    = 1'b0;
    case (instruction)
      OP_R_TYPE: begin
        d_reg_write = 1'b1;
        d_alu_op    = ALU_R;
      end
      OP_LOAD: begin
        d_alu_src    = 1'b1;
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
        d_mem_read   = 1'b1;
      end
      OP_STORE: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        d_branch = 1'b1;
        d_alu_op = ALU_SUB;
      end
      OP_I_ALU: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op    = ALU_I;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch     <= 1'b0;
      mem_read   <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_op     <= ALU_ADD;
      mem_write  <= 1'b0;
      alu_src    <= 1'b0;
      reg_write  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      branch     <= d_branch;
      mem_read   <= d_mem_read;
      mem_to_reg <= d_mem_to_reg;
      alu_op     <= d_alu_op;
      mem_write  <= d_mem_write;
      alu_src    <= d_alu_src;
      reg_write  <= d_reg_write;
      illegal    <= d_illegal;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues the table decode of each
// opcode it applies, and a monitor pops and compares one cycle later.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] instruction;
  logic       branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal;
  logic [1:0] alu_op;

  int checks = 0;
  int failures = 0;
  int sweep_illegal = 0;
  bit sweep_on = 1'b0;

  // Control word order: alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0], illegal
  logic [8:0] ref_tab [logic [6:0]];
  logic [8:0] exp_q [$];

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instruction(instruction),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ref_decode(input logic [6:0] op);
    if (ref_tab.exists(op)) return ref_tab[op];
    return 9'b000000001;
  endfunction

  function automatic logic [8:0] dut_word();
    return {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, illegal};
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] expv);
    logic [8:0] got;
    got = dut_word();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got=%b expected=%b (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic got, input logic expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got=%b expected=%b (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op);
    @(negedge clk);
    instruction = op;
    exp_q.push_back(ref_decode(op));
  endtask

  // Asserts reset between edges; any queued decode is discarded.
  task automatic pulseReset(input string name);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput(name, 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: outputs after edge N reflect the opcode applied before edge N.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      checkOutput("decode", e);
      checkFlag("rd_wr_exclusive", mem_read & mem_write, 1'b0);
      checkFlag("write_no_regwrite", mem_write & reg_write, 1'b0);
      if (sweep_on && illegal) sweep_illegal++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ref_tab[7'b0110011] = 9'b001000100;
    ref_tab[7'b0000011] = 9'b111100000;
    ref_tab[7'b0100011] = 9'b100010000;
    ref_tab[7'b1100011] = 9'b000001010;
    ref_tab[7'b0010011] = 9'b101000110;

    rst_n = 1'b0;
    instruction = 7'b0110011;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ref_decode(instruction));
    @(posedge clk);
    #2;
    checkOutput("first_after_reset", 9'b001000100);

    foreach (ref_tab[op]) begin
      applyStimulus(op);
      applyStimulus(op);
    end
    foreach (ref_tab[op]) applyStimulus(op);
    applyStimulus(7'b1111111);
    applyStimulus(7'b0000000);
    applyStimulus(7'b1101111);
    drain();

    applyStimulus(7'b0000011);
    @(posedge clk);
    #3;
    checkOutput("load_before_reset", 9'b111100000);
    pulseReset("async_reset_load");
    drain();

    sweep_on = 1'b1;
    for (int i = 0; i < 128; i++) applyStimulus(7'(i));
    drain();
    sweep_on = 1'b0;
    checks++;
    if (sweep_illegal != 123) begin
      failures++;
      $display("[TB] FAIL sweep_illegal_count: got=%0d expected=123", sweep_illegal);
    end

    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      if ($urandom_range(0, 1) == 0) op = 7'($urandom_range(0, 127));
      else case ($urandom_range(0, 4))
        0: op = 7'b0110011;
        1: op = 7'b0000011;
        2: op = 7'b0100011;
        3: op = 7'b1100011;
        default: op = 7'b0010011;
      endcase
      applyStimulus(op);
      if ($urandom_range(0, 39) == 0) begin
        #2;
        pulseReset("async_reset_random");
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
